// File: rtl/draw_ship.sv
// Ship sprite overlay stage: frame-latched position, ROM row addressing and a
// three-stage pixel pipeline that keeps timing, counters and colour aligned.
module draw_ship #(
   parameter int          SHIP_W     = 48,
   parameter int          SHIP_H     = 24,
   parameter int          SHIP_COUNT = 2,
   parameter logic [11:0] SHIP_COLOR = 12'hFFF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [10:0]       hcount_in,
   input  logic [10:0]       vcount_in,
   input  logic              hsync_in,
   input  logic              vsync_in,
   input  logic              hblnk_in,
   input  logic              vblnk_in,
   input  logic [11:0]       rgb_in,
   input  logic [10:0]       xpos,
   input  logic [10:0]       ypos,
   input  logic [1:0]        ship_sel,
   input  logic              ship_en,
   output logic [8:0]        rom_addr,
   input  logic [SHIP_W-1:0] ship_line_pixels_in,
   output logic [10:0]       hcount_out,
   output logic [10:0]       vcount_out,
   output logic              hsync_out,
   output logic              vsync_out,
   output logic              hblnk_out,
   output logic              vblnk_out,
   output logic [11:0]       rgb_out
);
   localparam int CW = $clog2(SHIP_W);

   typedef struct packed {
      logic [10:0] hcount;
      logic [10:0] vcount;
      logic        hsync;
      logic        vsync;
      logic        hblnk;
      logic        vblnk;
      logic [11:0] rgb;
   } timing_t;

   timing_t       t_in, t_d1, t_d2, t_q;
   logic          prev_vblnk, en_l;
   logic [10:0]   xpos_l, ypos_l;
   logic [1:0]    sel_l;
   logic [11:0]   row, col;
   logic          hit, hit_d1, hit_d2;
   logic [8:0]    addr_next;
   logic [CW-1:0] col_d1, col_d2, bit_idx;

   assign t_in = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in};

   // 12-bit differences plus explicit >= checks prevent wrap-around hits at the edges
   always_comb begin
      row  = {1'b0, vcount_in} - {1'b0, ypos_l};
      col  = {1'b0, hcount_in} - {1'b0, xpos_l};
      hit  = en_l && (vcount_in >= ypos_l) && (row < 12'(SHIP_H)) &&
             (hcount_in >= xpos_l) && (col < 12'(SHIP_W)) &&
             (int'(sel_l) < SHIP_COUNT) && !hblnk_in && !vblnk_in;
      addr_next = '0;
      if (hit)
         addr_next = 9'(32'd1 + 32'(sel_l) * 32'(SHIP_H) + 32'(row));
   end

   assign bit_idx = CW'(SHIP_W - 1) - col_d2;

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_vblnk <= 1'b0;
         en_l       <= 1'b0;
         xpos_l     <= '0;
         ypos_l     <= '0;
         sel_l      <= '0;
         rom_addr   <= '0;
         col_d1     <= '0;
         col_d2     <= '0;
         hit_d1     <= 1'b0;
         hit_d2     <= 1'b0;
         t_d1       <= '0;
         t_d2       <= '0;
         t_q        <= '0;
      end else begin
         prev_vblnk <= vblnk_in;
         if (vblnk_in && !prev_vblnk) begin
            xpos_l <= xpos;
            ypos_l <= ypos;
            sel_l  <= ship_sel;
            en_l   <= ship_en;
         end
         rom_addr <= addr_next;
         col_d1   <= col[CW-1:0];
         hit_d1   <= hit;
         t_d1     <= t_in;
         col_d2   <= col_d1;
         hit_d2   <= hit_d1;
         t_d2     <= t_d1;
         t_q      <= t_d2;
         if (hit_d2 && ship_line_pixels_in[bit_idx])
            t_q.rgb <= SHIP_COLOR;
      end
   end

   assign hcount_out = t_q.hcount;
   assign vcount_out = t_q.vcount;
   assign hsync_out  = t_q.hsync;
   assign vsync_out  = t_q.vsync;
   assign hblnk_out  = t_q.hblnk;
   assign vblnk_out  = t_q.vblnk;
   assign rgb_out    = t_q.rgb;

endmodule

// File: doc/draw_ship.md
Name: draw_ship

Overview:
- Pixel-overlay stage that drives the ship ROM and consumes its 48-bit line output.
- Takes the VGA timing/colour stream from the upstream background stage.
- Computes the ROM row address for the selected ship at a frame-latched position.
- Paints set ROM bits in SHIP_COLOR and forwards timing signals delayed to match the pipeline.

Parameters:
- SHIP_W, 48, ship width in pixels (one ROM bit per pixel, MSB = leftmost).
- SHIP_H, 24, ship height in rows (ROM lines per ship).
- SHIP_COUNT, 2, number of ship images stored in ROM.
- SHIP_COLOR, 12'hF_F_F, RGB444 colour for set pixels.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous, active-high reset.
- hcount_in  in  11  horizontal pixel counter.
- vcount_in  in  11  vertical line counter.
- hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  VGA timing.
- rgb_in  in  12  background colour.
- xpos  in  11  ship left column, requested.
- ypos  in  11  ship top line, requested.
- ship_sel  in  2  ship image index.
- ship_en  in  1  draw enable.
- rom_addr  out  9  address to ship ROM, registered.
- ship_line_pixels_in  in  48  ROM line; valid one clk after rom_addr.
- hcount_out, vcount_out  out  11  delayed counters.
- hsync_out, vsync_out, hblnk_out, vblnk_out  out  1  delayed timing.
- rgb_out  out  12  overlaid colour.

Behaviour:
- Frame latch:
  - xpos/ypos/ship_sel/ship_en are captured into internal regs on the vblnk_in rising edge only (prev-vblnk register, edge = vblnk_in & ~prev).
  - Changes mid-frame have no effect until the next edge, so there is no tearing.
  - After reset, latched values are 0 and en = 0 until the first edge.
- Stage 1 (edge n+1):
  - row = vcount_in − ypos_l and col = hcount_in − xpos_l, computed in 12 bits.
  - hit = en_l & vcount_in ≥ ypos_l & row < SHIP_H & hcount_in ≥ xpos_l & col < SHIP_W & ship_sel_l < SHIP_COUNT & ~hblnk_in & ~vblnk_in.
  - rom_addr <= hit ? 1 + ship_sel_l·SHIP_H + row : 0. ROM line 0 is unused; ship 0 occupies 1–24, ship 1 occupies 25–48.
  - col, hit and all timing signals plus rgb are registered.
- Stage 2 (edge n+2): the ROM registers its line. Stage-1 col, hit, timing and rgb are delayed once more.
- Stage 3 (edge n+3):
  - rgb_out <= (hit_d2 & ship_line_pixels_in[SHIP_W−1−col_d2]) ? SHIP_COLOR : rgb_d2.
  - Timing outputs <= d2 copies.
- Total latency is 3 clk for every output relative to the inputs, including non-hit pixels.
- Reset (sync) clears all pipeline registers to 0: rom_addr = 0, rgb_out = 0, all timing outputs = 0, latched position = 0, en = 0. A reset asserted mid-line takes effect at the next edge. The pipeline refills in 3 clk after release.
- Edge clipping:
  - A ship at xpos > 799−47 is clipped at the active-area right edge by hblnk.
  - No wrap to column 0 is permitted; the 12-bit compare guarantees this.
  - ypos near the bottom is clipped the same way by vblnk.
- ship_sel ≥ SHIP_COUNT: no hit; rgb passes through; rom_addr = 0.
- Clear ROM bit inside the window: background passes through, so the ship is transparent there.

Test Plan:
- Reset held for 5 clk with random inputs -> all outputs 0, rom_addr 0; after release, outputs equal inputs delayed 3 clk.
- en=1, sel=0, xpos=100, ypos=50 latched at vblnk; scan a frame:
  - At vcount=53, hcount=100 -> rom_addr=4 one clk later.
  - rgb_out = SHIP_COLOR exactly at output hcount 112..135 for vcount 53..70.
  - All other pixels equal rgb_in.
- sel=1, same position -> rom_addr sweeps 25..48 across rows 50..73; all-zero ROM lines -> rgb_out == rgb_in throughout.
- xpos changes from 100 to 300 at vcount=60 mid-frame -> the rest of the frame still draws at 100; the next frame draws at 300.
- xpos=780 -> columns 780..799 drawn per ROM bits; nothing drawn at hcount 0..27 of the next line; sel=3 -> no pixel drawn.
- Reset pulsed for 1 clk mid-ship-row -> the following 3 outputs are 0/background; latched en=0, so no ship is drawn until the next vblnk edge.
